// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures the high time of an RC-servo pulse and recovers an
// 8-bit position, with strobes for malformed pulses and a loss-of-signal level.
module servo_pwm_decoder #(
    parameter int CLK_FREQUENCY = 12000000,
    parameter int MIN_PULSE_US  = 1000,
    parameter int MAX_PULSE_US  = 2000,
    parameter int TIMEOUT_US    = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [7:0] pos,
    output logic       pos_valid,
    output logic       pulse_err,
    output logic       signal_lost
);

    localparam int CYC_PER_US = CLK_FREQUENCY / 1000000;
    localparam int MIN_CYC    = MIN_PULSE_US * CYC_PER_US;
    localparam int MAX_CYC    = MAX_PULSE_US * CYC_PER_US;
    localparam int STEP_RAW   = (MAX_CYC - MIN_CYC) / 256;
    localparam int STEP_CYC   = (STEP_RAW < 1) ? 1 : STEP_RAW;
    localparam int SHORT_CYC  = MIN_CYC / 2;
    localparam int LONG_CYC   = MAX_CYC + MIN_CYC / 2;
    localparam int TO_CYC     = TIMEOUT_US * CYC_PER_US;

    localparam int CNT_MAX = (TO_CYC > LONG_CYC + 1) ? TO_CYC : LONG_CYC + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STEP_W  = $clog2(STEP_CYC + 1);

    localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0]  SHORT_C   = CNT_W'(SHORT_CYC);
    localparam logic [CNT_W-1:0]  LONG_C    = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0]  TO_C      = CNT_W'(TO_CYC);
    localparam logic [CNT_W-1:0]  TO_M1_C   = CNT_W'(TO_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);

    localparam logic [1:0] ST_WAIT_LOW  = 2'd0;
    localparam logic [1:0] ST_WAIT_RISE = 2'd1;
    localparam logic [1:0] ST_HIGH      = 2'd2;

    logic              sync1_q, s_q, s_prev_q;
    logic [1:0]        sync_vld_q;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  w_q, w_d, p_q, p_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [7:0]        acc_q, acc_d, pos_q, pos_d;
    logic              pos_valid_q, pos_valid_d;
    logic              pulse_err_q, pulse_err_d;
    logic              lost_q, lost_d;
    logic              rise;

    assign rise = s_q & ~s_prev_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d     = state_q;
        w_d         = w_q;
        p_d         = p_q;
        step_d      = step_q;
        acc_d       = acc_q;
        pos_d       = pos_q;
        pos_valid_d = 1'b0;
        pulse_err_d = 1'b0;
        lost_d      = lost_q;

        // Period watchdog runs in every state; a rise restarts it.
        if (rise) begin
            p_d = '0;
        end else if (p_q != TO_C) begin
            p_d = p_q + 1'b1;
            if (p_q == TO_M1_C) lost_d = 1'b1;
        end

        case (state_q)
            ST_WAIT_LOW: begin
                // Synchronizer output is meaningless until it has refilled after reset.
                if (!s_q && sync_vld_q[1]) state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    w_d     = CNT_W'(1);
                    step_d  = '0;
                    acc_d   = '0;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (s_q) begin
                    w_d = w_q + 1'b1;
                    if (w_q == LONG_C) begin
                        pulse_err_d = 1'b1;
                        state_d     = ST_WAIT_LOW;
                    end else if (w_q >= MIN_C) begin
                        if (step_q == STEP_LAST) begin
                            step_d = '0;
                            if (acc_q != 8'hFF) acc_d = acc_q + 1'b1;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end else begin
                    // Written after the watchdog so a completing pulse beats a timeout.
                    if (w_q < SHORT_C) begin
                        pulse_err_d = 1'b1;
                    end else begin
                        pos_d       = acc_q;
                        pos_valid_d = 1'b1;
                        lost_d      = 1'b0;
                    end
                    state_d = ST_WAIT_RISE;
                end
            end
            default: state_d = ST_WAIT_LOW;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            s_q         <= 1'b0;
            s_prev_q    <= 1'b0;
            sync_vld_q  <= 2'b00;
            state_q     <= ST_WAIT_LOW;
            w_q         <= '0;
            p_q         <= '0;
            step_q      <= '0;
            acc_q       <= '0;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
            pulse_err_q <= 1'b0;
            lost_q      <= 1'b1;
        end else begin
            sync1_q     <= pwm_in;
            s_q         <= sync1_q;
            s_prev_q    <= s_q;
            sync_vld_q  <= {sync_vld_q[0], 1'b1};
            state_q     <= state_d;
            w_q         <= w_d;
            p_q         <= p_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            pulse_err_q <= pulse_err_d;
            lost_q      <= lost_d;
        end
    end

    assign pos         = pos_q;
    assign pos_valid   = pos_valid_q;
    assign pulse_err   = pulse_err_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder, run with scaled-down timing parameters
// (1 cycle per us) so the timeout and full-scale pulses stay short.
module tb_servo_pwm_decoder;

    localparam int CLK_HZ   = 1000000;
    localparam int MIN_US   = 256;
    localparam int MAX_US   = 768;
    localparam int TO_US    = 3000;
    // Expected-side constants: MIN=256, STEP=2, SHORT=128, LONG=896, TO=3000 cycles.
    localparam int MIN_CYC   = 256;
    localparam int STEP_CYC  = 2;
    localparam int LONG_CYC  = 896;
    localparam int TO_CYC    = 3000;
    localparam int GAP       = 60;

    typedef struct {
        int unsigned high_cyc;
        bit          exp_err;
        logic [7:0]  exp_pos;
    } vec_t;

    typedef struct {
        bit         err;
        logic [7:0] pos;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwm_in = 1'b0;
    logic [7:0] pos;
    logic       pos_valid, pulse_err, signal_lost;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[13];

    servo_pwm_decoder #(
        .CLK_FREQUENCY(CLK_HZ),
        .MIN_PULSE_US (MIN_US),
        .MAX_PULSE_US (MAX_US),
        .TIMEOUT_US   (TO_US)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .pos        (pos),
        .pos_valid  (pos_valid),
        .pulse_err  (pulse_err),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit err, input logic [7:0] p);
        exp_t e;
        e.err = err;
        e.pos = p;
        sb.push_back(e);
    endtask

    task automatic pulse(input int hi, input int lo);
        @(posedge clk); #1 pwm_in = 1'b1;
        repeat (hi) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    // Scoreboard consumer: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && (pos_valid || pulse_err)) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, pulse_err, pos_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", {30'd0, pulse_err, pos_valid}, e.err ? 32'd2 : 32'd1);
                check("strobe_pos", {24'd0, pos}, {24'd0, e.pos});
                if (pos_valid) check("lost_clears_with_strobe", {31'd0, signal_lost}, 32'd0);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] prev_pos;

        vecs[0]  = '{512,  1'b0, 8'd128};
        vecs[1]  = '{256,  1'b0, 8'd0};
        vecs[2]  = '{768,  1'b0, 8'd255};
        vecs[3]  = '{512,  1'b0, 8'd128};
        vecs[4]  = '{127,  1'b1, 8'd128};
        vecs[5]  = '{128,  1'b0, 8'd0};
        vecs[6]  = '{765,  1'b0, 8'd254};
        vecs[7]  = '{896,  1'b0, 8'd255};
        vecs[8]  = '{257,  1'b0, 8'd0};
        vecs[9]  = '{258,  1'b0, 8'd1};
        vecs[10] = '{500,  1'b0, 8'd122};
        vecs[11] = '{1000, 1'b1, 8'd122};
        vecs[12] = '{512,  1'b0, 8'd128};

        repeat (3) @(posedge clk);
        #1;
        check("reset_pos", {24'd0, pos}, 32'd0);
        check("reset_pos_valid", {31'd0, pos_valid}, 32'd0);
        check("reset_pulse_err", {31'd0, pulse_err}, 32'd0);
        check("reset_signal_lost", {31'd0, signal_lost}, 32'd1);
        rst = 1'b0;
        repeat (100) @(posedge clk);

        for (int i = 0; i < 13; i++) begin
            push(vecs[i].exp_err, vecs[i].exp_pos);
            pulse(int'(vecs[i].high_cyc), GAP);
        end
        check("lost_low_after_pulses", {31'd0, signal_lost}, 32'd0);

        // Too-long pulse: error lands LONG+1 cycles after s rises (s lags pwm_in by 2 edges).
        push(1'b1, 8'd128);
        @(posedge clk); #1 pwm_in = 1'b1;
        repeat (LONG_CYC + 2) @(posedge clk);
        #1 check("long_err_not_yet", {31'd0, pulse_err}, 32'd0);
        @(posedge clk); #1 check("long_err_on_time", {31'd0, pulse_err}, 32'd1);
        @(posedge clk); #1 check("long_err_one_cycle", {31'd0, pulse_err}, 32'd0);
        repeat (1000 - (LONG_CYC + 4)) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (GAP) @(posedge clk);
        push(1'b0, 8'd128);
        pulse(512, GAP);

        // Pulse train with a period well inside the timeout keeps the signal alive.
        push(1'b0, 8'd128);
        pulse(512, 2000 - 512);
        push(1'b0, 8'd128);
        pulse(512, 2000 - 512);
        check("lost_low_in_train", {31'd0, signal_lost}, 32'd0);

        // Last pulse, then silence: p is cleared on the edge after s rises, so
        // signal_lost rises TO_CYC+1 edges after s (TO_CYC+3 after pwm_in).
        push(1'b0, 8'd128);
        @(posedge clk); #1 pwm_in = 1'b1;
        repeat (512) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (TO_CYC + 2 - 512) @(posedge clk);
        #1 check("timeout_not_yet", {31'd0, signal_lost}, 32'd0);
        @(posedge clk); #1 check("timeout_on_time", {31'd0, signal_lost}, 32'd1);
        check("timeout_pos_holds", {24'd0, pos}, 32'd128);

        // A rise alone does not clear signal_lost; the completed pulse does.
        push(1'b0, 8'd128);
        @(posedge clk); #1 pwm_in = 1'b1;
        repeat (300) @(posedge clk);
        #1 check("lost_held_mid_pulse", {31'd0, signal_lost}, 32'd1);
        repeat (212) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (GAP) @(posedge clk);
        #1 check("lost_cleared_by_pulse", {31'd0, signal_lost}, 32'd0);

        // Reset in the middle of a pulse: the remainder must produce no strobe.
        @(posedge clk); #1 pwm_in = 1'b1;
        repeat (300) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_pos", {24'd0, pos}, 32'd0);
        check("midrst_signal_lost", {31'd0, signal_lost}, 32'd1);
        rst = 1'b0;
        repeat (400) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (GAP) @(posedge clk);
        check("midrst_no_strobe_pending", sb.size(), 32'd0);
        check("midrst_pos_unchanged", {24'd0, pos}, 32'd0);
        push(1'b0, 8'd128);
        pulse(512, GAP);

        // Loopback-style sweep: a generator emitting MIN + k*STEP cycles for position k.
        prev_pos = 8'd0;
        for (int k = 0; k <= 255; k += 15) begin
            push(1'b0, 8'(k));
            pulse(MIN_CYC + STEP_CYC * k, GAP);
            #1;
            check("sweep_monotonic", {31'd0, (pos >= prev_pos)}, 32'd1);
            check("sweep_signal_alive", {31'd0, signal_lost}, 32'd0);
            prev_pos = pos;
        end

        repeat (10) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
- Receive-side counterpart of the servo PWM generator. Measures the high time of an incoming RC-servo pulse train and recovers an 8-bit position.
- Position 0 = MIN_PULSE_US, 255 = at or beyond the top of the span.
- Sits on a GPIO input of the SoM. Used for loopback-testing the generator and for taking commands from an external RC receiver.
- Also flags malformed pulses and loss of signal.

Parameters:
- CLK_FREQUENCY, 12000000: clk frequency in Hz.
- MIN_PULSE_US, 1000: pulse width mapped to position 0.
- MAX_PULSE_US, 2000: pulse width mapped to full scale.
- TIMEOUT_US, 25000: time without a rising edge before signal_lost asserts.

Derived constants (localparam, integer arithmetic):
- CYC_PER_US = CLK_FREQUENCY/1000000.
- MIN_CYC = MIN_PULSE_US*CYC_PER_US.
- MAX_CYC = MAX_PULSE_US*CYC_PER_US.
- STEP_CYC = (MAX_CYC-MIN_CYC)/256, floored, minimum 1.
- SHORT_CYC = MIN_CYC/2.
- LONG_CYC = MAX_CYC+MIN_CYC/2.
- TO_CYC = TIMEOUT_US*CYC_PER_US.
- With defaults: 12000, 24000, 46, 6000, 30000, 300000.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- pwm_in  input  1  asynchronous servo pulse input.
- pos  output  8  last decoded position; holds between updates.
- pos_valid  output  1  one-cycle strobe when pos is updated.
- pulse_err  output  1  one-cycle strobe on a too-short or too-long pulse.
- signal_lost  output  1  level; no rising edge for TO_CYC cycles.

Behaviour:
- Reset values: pos=0, pos_valid=0, pulse_err=0, signal_lost=1, synchronizer flops=0, all counters=0, state=WAIT_LOW.
- Input path: 2-flop synchronizer, then a registered copy for edge detect. A rise is seen 2-3 cycles after the pad edge. Counting uses the synchronized signal s.
- Width counter w and period counter p: each wide enough for TO_CYC, saturating, never wrap.
- State WAIT_LOW:
  - Ignore s while it is high; this blocks partial pulses after reset or after an abort.
  - s==0 -> WAIT_RISE.
- State WAIT_RISE:
  - On a rising edge of s: w=1, step counter=0, pos_acc=0, p=0 -> HIGH.
- State HIGH: w increments each cycle s==1.
  - Once w>=MIN_CYC, pos_acc increments every STEP_CYC cycles, saturating at 255.
  - Result: pos_acc = min(255, floor((w-MIN_CYC)/STEP_CYC)) for w>=MIN_CYC, else 0. No divider.
  - If w reaches LONG_CYC+1 while s==1: pulse_err=1 for one cycle -> WAIT_LOW. pos unchanged, no pos_valid.
  - On the first cycle s==0 (falling edge seen), register one of:
    - w<SHORT_CYC: pulse_err strobe, pos unchanged.
    - otherwise: pos<=pos_acc, pos_valid strobe, signal_lost<=0.
  - Either way -> WAIT_RISE. Strobes appear in the cycle after the fall is seen.
  - Boundaries: w==SHORT_CYC is valid (pos=0); w==LONG_CYC is valid (pos=255).
- Period watchdog: p increments every cycle in all states and clears on each rising edge of s. When p reaches TO_CYC, signal_lost<=1 and pos holds. Only a valid pulse clears signal_lost; a rise alone does not.
- Simultaneous events: the timeout and a pulse completion in the same cycle -> the completion wins, so signal_lost=0.
- Outputs are registered. pos_valid and pulse_err are never both 1 in the same cycle.
- Reset mid-pulse: returns to WAIT_LOW. The remainder of an in-flight pulse produces no strobe.

Test Plan:
- Defaults, after reset, pwm_in low 100 cycles then high 18000 cycles (1500us) -> one pos_valid, pos=130 (6000/46), signal_lost falls with the strobe, pulse_err never set.
- High 12000 cycles -> pos=0. High 24000 cycles -> pos=255 (saturated). High 5999 cycles -> pulse_err only, pos keeps 130. High exactly 6000 cycles -> pos_valid with pos=0.
- High 36000 cycles -> pulse_err exactly 30001 cycles after the synchronized rise, no pos_valid at the fall; the next 18000-cycle pulse decodes to 130.
- Pulse train of 18000 high/240000 period, then pwm_in held low -> signal_lost=1 exactly 300000 cycles after the last synchronized rise, pos stays 130. Next valid pulse clears signal_lost.
- Assert rst mid-pulse with pwm_in high, release it, keep high 10000 more cycles, then fall -> no strobes; the following full pulse decodes normally.
- Loopback from the servo generator driven with pos sweeping 0->255 -> decoded pos is monotonic non-decreasing, no pulse_err, signal_lost=0 after the first pulse.
